// File: rtl/conv_fetch_seq.sv
// conv_fetch_seq: streams cfg_len activations out of a 1-cycle-latency SRAM.
// Each element costs one READ cycle (SRAM access, `read` strobe) followed by
// one or more LOAD cycles (valid/ready handshake, `load` strobe), so `read`
// and `load` alternate and can never coincide.
module conv_fetch_seq #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              read,
  output logic              load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  elem_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  // Set for exactly the first LOAD cycle of an element, when mem_rdata is live.
  logic              first_q, first_d;
  logic              hs_s;

  // Next-state, datapath updates and all strobes/outputs decoded from state.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    elem_cnt_d = elem_cnt_q;
    hold_d     = hold_q;
    first_d    = 1'b0;
    hs_s       = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    read       = 1'b0;
    load       = 1'b0;
    out_valid  = 1'b0;
    out_data   = {DATA_W{1'b0}};
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    elem_cnt   = elem_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = cfg_base_addr;
          len_d      = cfg_len;
          idx_d      = {CNT_W{1'b0}};
          elem_cnt_d = {CNT_W{1'b0}};
          state_d    = (cfg_len != {CNT_W{1'b0}}) ? S_READ : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        read      = 1'b1;
        // Address arithmetic wraps modulo 2^ADDR_W by truncation.
        mem_addr  = base_q + ADDR_W'(idx_q);
        first_d   = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        out_valid = 1'b1;
        if (first_q) begin
          out_data = mem_rdata;
          hold_d   = mem_rdata;
        end else begin
          out_data = hold_q;
        end
        // A flush in the same cycle cancels the handshake entirely.
        hs_s = out_ready & ~flush;
        load = hs_s;
        if (hs_s) begin
          elem_cnt_d = elem_cnt_q + CNT_ONE;
          idx_d      = idx_q + CNT_ONE;
          state_d    = ((elem_cnt_q + CNT_ONE) == len_q) ? S_DONE : S_READ;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over start and handshake: drop to IDLE, keep count and config.
    if (flush) begin
      state_d    = S_IDLE;
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      elem_cnt_d = elem_cnt_q;
      first_d    = 1'b0;
    end else begin
      first_d = first_d;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= {ADDR_W{1'b0}};
      len_q      <= {CNT_W{1'b0}};
      idx_q      <= {CNT_W{1'b0}};
      elem_cnt_q <= {CNT_W{1'b0}};
      hold_q     <= {DATA_W{1'b0}};
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      elem_cnt_q <= elem_cnt_d;
      hold_q     <= hold_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_conv_fetch_seq.sv
// Testbench for conv_fetch_seq: table of transfers with a scoreboard of
// expected addresses/data, plus hand sequences for flush and async reset.
module tb_conv_fetch_seq;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              flush;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [CNT_W-1:0]  cfg_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = 8'h00;
  logic              read;
  logic              load;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  elem_cnt;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  len;
    int                stall;     // out_ready=0 cycles on the first element
    bit                glitch;    // pulse start mid-transfer
    int                exp_done;  // expected cycle of done relative to T
  } vec_t;

  vec_t vecs[7];

  conv_fetch_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .read(read), .load(load), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .elem_cnt(elem_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM model: word content is the address low byte, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr[7:0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, mem_rd_en, mem_addr, read, load, out_valid, out_data, elem_cnt, busy, done};
  endfunction

  task automatic run_xfer(input vec_t v);
    int rel, nload, nread;
    bit fin;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(a[7:0]);
    end
    @(negedge clk);
    cfg_base_addr = v.base;
    cfg_len       = v.len;
    start         = 1'b1;
    out_ready     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rel = 0; nload = 0; nread = 0; fin = 1'b0;
    while (!fin && rel < 1000) begin
      @(negedge clk);
      rel++;
      out_ready = !(rel >= 2 && rel < 2 + v.stall);
      start     = v.glitch && (rel == 3);
      if (v.glitch) begin
        cfg_base_addr = 12'h100;
        cfg_len       = 8'd7;
      end
      #1;
      chk("read_load_excl", {63'd0, read & load}, 64'd0);
      if (read) begin
        nread++;
        chk("read_time", rel, 2 * nread - 1 + ((nread > 1) ? v.stall : 0));
        chk("mem_rd_en_with_read", {63'd0, mem_rd_en}, 64'd1);
        if (exp_addr_q.size() > 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        else chk("read_count_excess", nread, v.len);
      end
      if (out_valid) begin
        chk("no_reread_in_load", {63'd0, mem_rd_en}, 64'd0);
        if (exp_data_q.size() > 0) begin
          chk("out_data", out_data, exp_data_q[0]);
          if (load) void'(exp_data_q.pop_front());
        end else begin
          chk("valid_count_excess", nload, v.len);
        end
      end
      if (load) begin
        nload++;
        chk("load_time", rel, 2 * nload + v.stall);
      end
      if (done) begin
        chk("done_time", rel, v.exp_done);
        chk("elem_cnt_final", elem_cnt, v.len);
        chk("load_count", nload, v.len);
        chk("read_count", nread, v.len);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    if (!fin) chk("done_timeout", rel, v.exp_done);
    @(negedge clk);
    #1;
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);
    chk("elem_cnt_hold", elem_cnt, v.len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 12'h010, len: 8'd4,   stall: 0, glitch: 1'b0, exp_done: 9};
    vecs[1] = '{base: 12'h020, len: 8'd2,   stall: 3, glitch: 1'b0, exp_done: 8};
    vecs[2] = '{base: 12'h030, len: 8'd0,   stall: 0, glitch: 1'b0, exp_done: 1};
    vecs[3] = '{base: 12'h040, len: 8'd3,   stall: 0, glitch: 1'b1, exp_done: 7};
    vecs[4] = '{base: 12'hFFE, len: 8'd4,   stall: 0, glitch: 1'b0, exp_done: 9};
    vecs[5] = '{base: 12'h0FF, len: 8'd1,   stall: 0, glitch: 1'b0, exp_done: 3};
    vecs[6] = '{base: 12'h123, len: 8'd255, stall: 0, glitch: 1'b0, exp_done: 511};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cfg_base_addr = 12'h000; cfg_len = 8'd0;
    #12;
    chk("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_outputs", all_outs(), 64'd0);

    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // Flush during the LOAD cycle of element 3 with out_ready high.
    exp_addr_q.delete();
    exp_data_q.delete();
    begin
      int nload;
      nload = 0;
      @(negedge clk);
      cfg_base_addr = 12'h050; cfg_len = 8'd5; start = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int r = 1; r <= 6; r++) begin
        @(negedge clk);
        flush = (r == 6);
        #1;
        if (r < 6 && load) nload++;
      end
      chk("flush_loads_before", nload, 2);
      chk("flush_valid", {63'd0, out_valid}, 64'd1);
      chk("flush_no_load", {63'd0, load}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_idle", {63'd0, busy}, 64'd0);
      chk("flush_no_done", {63'd0, done}, 64'd0);
      chk("flush_elem_cnt", elem_cnt, 2);
      @(negedge clk);
      #1;
      chk("flush_still_no_done", {62'd0, busy, done}, 64'd0);
    end

    // Async reset dropped mid-LOAD, away from any clock edge.
    @(negedge clk);
    cfg_base_addr = 12'h060; cfg_len = 8'd3; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("pre_reset_in_load", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    #1;
    chk("reset_held_no_done", all_outs(), 64'd0);
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    run_xfer('{base: 12'h070, len: 8'd1, stall: 0, glitch: 1'b0, exp_done: 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
